sample_trigger_sequencer: RTL and testbench

- Sits between the game core's sound-port outputs (16-bit trigger and 16-bit stop levels) and the sample-playback engine.
- Converts level changes on those ports into discrete, ordered start/stop events.
- Buffers the events in a small FIFO and hands them out one per handshake.
- Tracks which channels are currently playing, so no edge is lost when the CPU toggles several bits at once or the playback engine stalls.

---
 rtl/sample_trig_pkg.sv | 36 +++
 rtl/sample_evt_fifo.sv | 53 +++++
 rtl/sample_trigger_sequencer.sv | 121 ++++++++++++
 tb/tb_sample_trigger_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_trig_pkg.sv
// Shared types and helpers for the sample trigger sequencer.
// Holds the event encoding, the FIFO entry layout and the lowest-index channel finder.
package sample_trig_pkg;

    localparam int PKG_CHANNELS = 16;
    localparam int PKG_CH_W     = 4;

    localparam logic EVT_START = 1'b0;
    localparam logic EVT_STOP  = 1'b1;

    typedef struct packed {
        logic [PKG_CH_W-1:0] ch;
        logic                stop;
    } evt_t;

    localparam int EVT_W = $bits(evt_t);

    typedef struct packed {
        logic                found;
        logic [PKG_CH_W-1:0] idx;
    } sel_t;

    // Walking from the top down leaves the lowest set index in the result.
    function automatic sel_t lowest_set(input logic [PKG_CHANNELS-1:0] vec);
        sel_t r;
        r = '0;
        for (int i = PKG_CHANNELS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.idx   = PKG_CH_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sample_evt_fifo.sv
// First-word-fall-through FIFO of start/stop events with an occupancy count.
// The head entry is visible combinationally; the caller never pushes while full.
module sample_evt_fifo
    import sample_trig_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [EVT_W-1:0] i_data,
    input  logic             i_pop,
    output logic [EVT_W-1:0] o_head,
    output logic [PTR_W:0]   o_count
);

    logic [EVT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/sample_trigger_sequencer.sv
// Turns trigger/stop level changes from the game core into ordered start/stop events,
// queues them for the playback engine and tracks which channels are playing.
module sample_trigger_sequencer
    import sample_trig_pkg::*;
#(
    parameter int CHANNELS   = PKG_CHANNELS,
    parameter int FIFO_DEPTH = 8,
    parameter int CH_W       = PKG_CH_W
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                I_ENA,
    input  logic                I_PAUSE,
    input  logic [CHANNELS-1:0] I_SOUND_PORT,
    input  logic [CHANNELS-1:0] I_SOUND_STOP,
    input  logic [CHANNELS-1:0] I_DONE,
    output logic                O_EVT_VALID,
    output logic [CH_W-1:0]     O_EVT_CH,
    output logic                O_EVT_STOP,
    input  logic                I_EVT_READY,
    output logic [CHANNELS-1:0] O_ACTIVE,
    output logic                O_OVERFLOW,
    input  logic                I_CLR_OVF
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                r_first;
    logic [CHANNELS-1:0] r_prev_port;
    logic [CHANNELS-1:0] r_prev_stop;
    logic [CHANNELS-1:0] r_pend_start;
    logic [CHANNELS-1:0] r_pend_stop;
    logic [CHANNELS-1:0] r_active;
    logic                r_ovf;

    logic                w_sample;
    logic [CHANNELS-1:0] w_rise_p;
    logic [CHANNELS-1:0] w_rise_s;
    sel_t                w_sel;
    logic [CH_W-1:0]     w_sel_idx;
    logic                w_push;
    logic                w_push_stop;
    evt_t                w_push_evt;
    evt_t                w_head;
    logic [CNT_W-1:0]    w_count;
    logic                w_pop;
    logic [CHANNELS-1:0] w_clr_start;
    logic [CHANNELS-1:0] w_clr_stop;
    logic [CHANNELS-1:0] w_pop_start;
    logic [CHANNELS-1:0] w_pop_stop;
    logic                w_coal;

    assign w_sample = I_ENA & ~I_PAUSE;
    assign w_rise_p = (w_sample && !r_first) ? (I_SOUND_PORT & ~r_prev_port) : '0;
    assign w_rise_s = (w_sample && !r_first) ? (I_SOUND_STOP & ~r_prev_stop) : '0;

    assign w_sel       = lowest_set(PKG_CHANNELS'(r_pend_stop | r_pend_start));
    assign w_sel_idx   = w_sel.idx[CH_W-1:0];
    assign w_push      = w_sel.found && (w_count < CNT_W'(FIFO_DEPTH));
    assign w_push_stop = r_pend_stop[w_sel_idx];
    assign w_push_evt  = '{ch: w_sel.idx, stop: w_push_stop ? EVT_STOP : EVT_START};

    assign O_EVT_VALID = (w_count != '0);
    assign w_pop       = O_EVT_VALID & I_EVT_READY;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        assign w_clr_stop[gi]  = w_push &  w_push_stop & (w_sel_idx == CH_W'(gi));
        assign w_clr_start[gi] = w_push & ~w_push_stop & (w_sel_idx == CH_W'(gi));
        assign w_pop_stop[gi]  = w_pop  &  w_head.stop & (w_head.ch == CH_W'(gi));
        assign w_pop_start[gi] = w_pop  & ~w_head.stop & (w_head.ch == CH_W'(gi));
    end

    // A rise only counts as merged if its pending bit is not leaving for the FIFO this cycle.
    assign w_coal = |((w_rise_p & r_pend_start & ~w_clr_start) |
                      (w_rise_s & r_pend_stop  & ~w_clr_stop));

    sample_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .i_push  (w_push),
        .i_data  (w_push_evt),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_first      <= 1'b1;
            r_prev_port  <= '0;
            r_prev_stop  <= '0;
            r_pend_start <= '0;
            r_pend_stop  <= '0;
            r_active     <= '0;
            r_ovf        <= 1'b0;
        end else begin
            if (w_sample) begin
                r_first     <= 1'b0;
                r_prev_port <= I_SOUND_PORT;
                r_prev_stop <= I_SOUND_STOP;
            end
            r_pend_start <= (r_pend_start & ~w_clr_start) | w_rise_p;
            r_pend_stop  <= (r_pend_stop  & ~w_clr_stop)  | w_rise_s;
            r_active     <= (r_active & ~I_DONE & ~w_pop_stop) | w_pop_start;
            if (w_coal) begin
                r_ovf <= 1'b1;
            end else if (I_CLR_OVF) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Head memory is not reset, so the channel/kind outputs are masked while empty.
    assign O_EVT_CH   = O_EVT_VALID ? w_head.ch   : '0;
    assign O_EVT_STOP = O_EVT_VALID ? w_head.stop : 1'b0;
    assign O_ACTIVE   = r_active;
    assign O_OVERFLOW = r_ovf;

endmodule

// File: tb/tb_sample_trigger_sequencer.sv
// Scoreboard bench: a cycle-level behavioural model predicts events and status,
// a negedge monitor compares every handshake and the status outputs against it.
module tb_sample_trigger_sequencer;

    localparam int NCH   = 16;
    localparam int DEPTH = 8;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        I_ENA = 1'b0;
    logic        I_PAUSE = 1'b0;
    logic [15:0] I_SOUND_PORT = '0;
    logic [15:0] I_SOUND_STOP = '0;
    logic [15:0] I_DONE = '0;
    logic        I_EVT_READY = 1'b0;
    logic        I_CLR_OVF = 1'b0;
    logic        O_EVT_VALID;
    logic [3:0]  O_EVT_CH;
    logic        O_EVT_STOP;
    logic [15:0] O_ACTIVE;
    logic        O_OVERFLOW;

    sample_trigger_sequencer #(
        .CHANNELS   (NCH),
        .FIFO_DEPTH (DEPTH),
        .CH_W       (4)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .I_ENA        (I_ENA),
        .I_PAUSE      (I_PAUSE),
        .I_SOUND_PORT (I_SOUND_PORT),
        .I_SOUND_STOP (I_SOUND_STOP),
        .I_DONE       (I_DONE),
        .O_EVT_VALID  (O_EVT_VALID),
        .O_EVT_CH     (O_EVT_CH),
        .O_EVT_STOP   (O_EVT_STOP),
        .I_EVT_READY  (I_EVT_READY),
        .O_ACTIVE     (O_ACTIVE),
        .O_OVERFLOW   (O_OVERFLOW),
        .I_CLR_OVF    (I_CLR_OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int ch;
        bit stop;
    } ev_t;

    int  tests = 0;
    int  fails = 0;
    int  n_hs = 0;
    int  n_start5 = 0;
    ev_t sb[$];
    ev_t m_fifo[$];
    bit  m_pstart[NCH];
    bit  m_pstop[NCH];
    bit  m_prev_p[NCH];
    bit  m_prev_s[NCH];
    bit  m_act[NCH];
    bit  m_first;
    bit  m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack16(input bit v[NCH]);
        logic [15:0] r;
        for (int i = 0; i < NCH; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_pstart[i] = 0; m_pstop[i] = 0; m_prev_p[i] = 0; m_prev_s[i] = 0; m_act[i] = 0;
        end
        m_first = 1;
        m_ovf   = 0;
        m_fifo.delete();
        sb.delete();
    endtask

    // One clock of behaviour: deliver head, move the lowest pending event into the queue,
    // then record new rising edges and update the playing set.
    task automatic model_step();
        int  occ;
        int  sel;
        bit  pop;
        bit  coal;
        bit  sample;
        ev_t popped;
        ev_t e;
        bit  took_start[NCH];
        bit  took_stop[NCH];
        bit  rp;
        bit  rs;
        if (!RESET_N) begin
            model_reset();
            return;
        end
        occ = m_fifo.size();
        pop = (occ != 0) && I_EVT_READY;
        if (pop) popped = m_fifo.pop_front();
        sel = -1;
        for (int i = 0; i < NCH; i++) begin
            took_start[i] = 0;
            took_stop[i]  = 0;
            if (sel < 0 && (m_pstop[i] || m_pstart[i])) sel = i;
        end
        if (sel >= 0 && occ < DEPTH) begin
            e.ch   = sel;
            e.stop = m_pstop[sel];
            if (e.stop) took_stop[sel] = 1; else took_start[sel] = 1;
            m_fifo.push_back(e);
            sb.push_back(e);
        end
        sample = I_ENA && !I_PAUSE;
        coal = 0;
        for (int i = 0; i < NCH; i++) begin
            rp = sample && !m_first && I_SOUND_PORT[i] && !m_prev_p[i];
            rs = sample && !m_first && I_SOUND_STOP[i] && !m_prev_s[i];
            if (rp && m_pstart[i] && !took_start[i]) coal = 1;
            if (rs && m_pstop[i] && !took_stop[i]) coal = 1;
            m_pstart[i] = (m_pstart[i] && !took_start[i]) || rp;
            m_pstop[i]  = (m_pstop[i] && !took_stop[i]) || rs;
            if (sample) begin
                m_prev_p[i] = I_SOUND_PORT[i];
                m_prev_s[i] = I_SOUND_STOP[i];
            end
            if (I_DONE[i]) m_act[i] = 0;
        end
        if (sample) m_first = 0;
        if (pop) m_act[popped.ch] = !popped.stop;
        if (coal) m_ovf = 1;
        else if (I_CLR_OVF) m_ovf = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    always @(negedge CLK) begin : monitor
        ev_t exp_e;
        if (RESET_N) begin
            check("valid", O_EVT_VALID, m_fifo.size() != 0);
            check("active", O_ACTIVE, pack16(m_act));
            check("overflow", O_OVERFLOW, m_ovf);
            if (O_EVT_VALID && I_EVT_READY) begin
                n_hs++;
                if (!O_EVT_STOP && O_EVT_CH == 4'd5) n_start5++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_evt: got ch=%0d stop=%0d expected none", O_EVT_CH, O_EVT_STOP);
                end else begin
                    exp_e = sb.pop_front();
                    $display("[TB] evt ch=%0d stop=%0d (exp ch=%0d stop=%0d)", O_EVT_CH, O_EVT_STOP, exp_e.ch, exp_e.stop);
                    check("evt_ch", O_EVT_CH, exp_e.ch);
                    check("evt_stop", O_EVT_STOP, exp_e.stop);
                end
            end
        end
    end

    initial begin
        int hs0;
        model_reset();

        // Port held high through reset never triggers.
        I_SOUND_PORT = 16'h0001;
        ticks(3);
        RESET_N = 1'b1;
        I_EVT_READY = 1'b1;
        for (int i = 0; i < 12; i++) begin
            I_ENA = i[0];
            tick();
        end
        check("reset_no_evt", n_hs, 0);
        I_ENA = 1'b1;
        I_SOUND_PORT = 16'h0000;
        ticks(3);

        // Two simultaneous rises, latency and ordering.
        I_SOUND_PORT = 16'h0014;
        tick();
        check("lat_n", O_EVT_VALID, 1'b0);
        tick();
        check("lat_n2", O_EVT_VALID, 1'b1);
        check("first_ch", O_EVT_CH, 4'd2);
        ticks(5);
        check("active_14", O_ACTIVE, 16'h0014);

        // Stop and start on the same channel together: stop first.
        hs0 = n_hs;
        I_SOUND_PORT = 16'h001C;
        I_SOUND_STOP = 16'h0008;
        ticks(6);
        check("ch3_events", n_hs - hs0, 2);
        check("ch3_active", O_ACTIVE[3], 1'b1);

        // Fill the FIFO with 16 starts while stalled, then drain.
        I_EVT_READY = 1'b0;
        I_SOUND_PORT = 16'h0000;
        ticks(2);
        I_SOUND_PORT = 16'hFFFF;
        ticks(14);
        check("full_valid", O_EVT_VALID, 1'b1);
        check("full_no_ovf", O_OVERFLOW, 1'b0);
        hs0 = n_hs;
        I_EVT_READY = 1'b1;
        ticks(30);
        check("all16", n_hs - hs0, 16);
        check("active_all", O_ACTIVE, 16'hFFFF);

        // Coalesce on channel 5 while the FIFO is full of stops.
        I_EVT_READY = 1'b0;
        I_SOUND_PORT = 16'h0000;
        I_SOUND_STOP = 16'h0000;
        ticks(2);
        I_SOUND_STOP = 16'h00FF;
        ticks(12);
        I_SOUND_PORT = 16'h0020;
        tick();
        I_SOUND_PORT = 16'h0000;
        tick();
        I_SOUND_PORT = 16'h0020;
        ticks(2);
        check("ovf_set", O_OVERFLOW, 1'b1);
        n_start5 = 0;
        I_EVT_READY = 1'b1;
        ticks(20);
        check("one_start5", n_start5, 1);
        I_CLR_OVF = 1'b1;
        tick();
        I_CLR_OVF = 1'b0;
        tick();
        check("ovf_clr", O_OVERFLOW, 1'b0);

        // Natural end on channel 7, then reset with events queued.
        I_SOUND_PORT = 16'h00A0;
        ticks(5);
        check("act7_on", O_ACTIVE[7], 1'b1);
        I_DONE = 16'h0080;
        tick();
        I_DONE = 16'h0000;
        check("act7_done", O_ACTIVE[7], 1'b0);
        I_EVT_READY = 1'b0;
        I_SOUND_PORT = 16'h00A7;
        ticks(6);
        check("pre_rst_valid", O_EVT_VALID, 1'b1);
        RESET_N = 1'b0;
        #1;
        check("rst_valid", O_EVT_VALID, 1'b0);
        check("rst_active", O_ACTIVE, 16'h0000);
        model_reset();
        ticks(2);
        RESET_N = 1'b1;
        tick();

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            I_ENA        = ($urandom_range(0, 3) != 0);
            I_PAUSE      = ($urandom_range(0, 9) == 0);
            I_EVT_READY  = ($urandom_range(0, 2) != 0);
            I_CLR_OVF    = ($urandom_range(0, 19) == 0);
            I_SOUND_PORT = I_SOUND_PORT ^ 16'($urandom & $urandom & $urandom);
            I_SOUND_STOP = I_SOUND_STOP ^ 16'($urandom & $urandom & $urandom & $urandom);
            I_DONE       = ($urandom_range(0, 7) == 0) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0000;
            tick();
        end
        I_ENA = 1'b0;
        I_PAUSE = 1'b0;
        I_DONE = '0;
        I_CLR_OVF = 1'b0;
        I_EVT_READY = 1'b1;
        ticks(40);
        check("drain_sb", sb.size(), 0);
        check("drain_valid", O_EVT_VALID, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
